// File: rtl/rocket_mem_window_if.sv
// AXI4 channel bundle shared by the Rocket-facing and DDR-facing sides of rocket_mem_window.
interface rocket_mem_window_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 6
);
  logic              ar_valid, ar_ready;
  logic [ADDR_W-1:0] ar_addr;
  logic [ID_W-1:0]   ar_id;
  logic [7:0]        ar_len;
  logic [2:0]        ar_size;
  logic [1:0]        ar_burst;
  logic [3:0]        ar_cache;
  logic              ar_lock;
  logic [2:0]        ar_prot;
  logic [3:0]        ar_qos;

  logic              aw_valid, aw_ready;
  logic [ADDR_W-1:0] aw_addr;
  logic [ID_W-1:0]   aw_id;
  logic [7:0]        aw_len;
  logic [2:0]        aw_size;
  logic [1:0]        aw_burst;
  logic [3:0]        aw_cache;
  logic              aw_lock;
  logic [2:0]        aw_prot;
  logic [3:0]        aw_qos;

  logic                w_valid, w_ready;
  logic [DATA_W-1:0]   w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic                w_last;

  logic              r_valid, r_ready;
  logic [ID_W-1:0]   r_id;
  logic [1:0]        r_resp;
  logic [DATA_W-1:0] r_data;
  logic              r_last;

  logic              b_valid, b_ready;
  logic [ID_W-1:0]   b_id;
  logic [1:0]        b_resp;

  modport master (
    output ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst, ar_cache, ar_lock, ar_prot, ar_qos,
    input  ar_ready,
    output aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst, aw_cache, aw_lock, aw_prot, aw_qos,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    input  r_valid, r_id, r_resp, r_data, r_last,
    output r_ready,
    input  b_valid, b_id, b_resp,
    output b_ready
  );

  modport slave (
    input  ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst, ar_cache, ar_lock, ar_prot, ar_qos,
    output ar_ready,
    input  aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst, aw_cache, aw_lock, aw_prot, aw_qos,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output r_valid, r_id, r_resp, r_data, r_last,
    input  r_ready,
    output b_valid, b_id, b_resp,
    input  b_ready
  );
endinterface

// File: rtl/rocket_mem_window.sv
// AXI4 address-window bridge: relocates SRC_BASE window to DST_BASE, answers misses with DECERR.
// Optional perf counters enabled by defining MEM_WIN_PERF_EN.
module rocket_mem_window #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 64,
  parameter int                ID_W     = 6,
  parameter int                WIN_LOG2 = 28,
  parameter logic [ADDR_W-1:0] SRC_BASE = ADDR_W'(32'h8000_0000),
  parameter logic [ADDR_W-1:0] DST_BASE = ADDR_W'(32'h1000_0000),
  parameter int                MAX_OUT  = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  rocket_mem_window_if.slave   s,
  rocket_mem_window_if.master  m,
  output logic [31:0]          perf_rd_bursts,
  output logic [31:0]          perf_wr_bursts,
  output logic [31:0]          perf_decerr
);
  localparam logic [ADDR_W-1:0] MASK      = ADDR_W'((64'd1 << WIN_LOG2) - 64'd1);
  localparam logic [7:0]        MAX_OUT_C = 8'(MAX_OUT);
  localparam logic [DATA_W-1:0] ERR_DATA  = '0;

  typedef enum logic {RD_IDLE, RD_ERR} rd_state_e;
  typedef enum logic [1:0] {WR_IDLE, WR_FWD, WR_ERR_W, WR_ERR_B} wr_state_e;

  rd_state_e       rd_state_q, rd_state_d;
  wr_state_e       wr_state_q, wr_state_d;
  logic [7:0]      rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [7:0]      rd_len_q, rd_len_d, rd_beat_q, rd_beat_d;
  logic [ID_W-1:0] rd_id_q, rd_id_d, wr_id_q, wr_id_d;
  logic            wlast_seen_q, wlast_seen_d;
  logic            live_q;

  logic ar_hit, aw_hit, rd_gate, wr_gate;
  logic s_ar_fire, s_aw_fire, s_r_fire, s_w_fire, s_b_fire;
  logic m_ar_fire, m_aw_fire, m_rlast_fire, m_b_fire;

  assign ar_hit       = (s.ar_addr & ~MASK) == SRC_BASE;
  assign aw_hit       = (s.aw_addr & ~MASK) == SRC_BASE;
  assign rd_gate      = live_q && rd_state_q == RD_IDLE && rd_cnt_q < MAX_OUT_C;
  assign wr_gate      = live_q && wr_state_q == WR_IDLE && wr_cnt_q != 8'hFF;
  assign s_ar_fire    = s.ar_valid & s.ar_ready;
  assign s_aw_fire    = s.aw_valid & s.aw_ready;
  assign s_r_fire     = s.r_valid & s.r_ready;
  assign s_w_fire     = s.w_valid & s.w_ready;
  assign s_b_fire     = s.b_valid & s.b_ready;
  assign m_ar_fire    = m.ar_valid & m.ar_ready;
  assign m_aw_fire    = m.aw_valid & m.aw_ready;
  assign m_rlast_fire = m.r_valid & m.r_ready & m.r_last;
  assign m_b_fire     = m.b_valid & m.b_ready;

  // live_q keeps every ready/valid low until the first clock after reset release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      live_q       <= 1'b0;
      rd_state_q   <= RD_IDLE;
      wr_state_q   <= WR_IDLE;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
      rd_len_q     <= '0;
      rd_beat_q    <= '0;
      rd_id_q      <= '0;
      wr_id_q      <= '0;
      wlast_seen_q <= 1'b0;
    end else begin
      live_q       <= 1'b1;
      rd_state_q   <= rd_state_d;
      wr_state_q   <= wr_state_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_len_q     <= rd_len_d;
      rd_beat_q    <= rd_beat_d;
      rd_id_q      <= rd_id_d;
      wr_id_q      <= wr_id_d;
      wlast_seen_q <= wlast_seen_d;
    end
  end

  always_comb begin
    rd_state_d   = rd_state_q;
    rd_len_d     = rd_len_q;
    rd_beat_d    = rd_beat_q;
    rd_id_d      = rd_id_q;
    rd_cnt_d     = rd_cnt_q + {7'd0, m_ar_fire} - {7'd0, m_rlast_fire};
    wr_state_d   = wr_state_q;
    wr_id_d      = wr_id_q;
    wlast_seen_d = wlast_seen_q;
    wr_cnt_d     = wr_cnt_q + {7'd0, m_aw_fire} - {7'd0, m_b_fire};

    case (rd_state_q)
      RD_IDLE: if (s_ar_fire && !ar_hit) begin
        rd_state_d = RD_ERR;
        rd_id_d    = s.ar_id;
        rd_len_d   = s.ar_len;
        rd_beat_d  = '0;
      end
      RD_ERR: if (s_r_fire) begin
        if (rd_beat_q == rd_len_q) rd_state_d = RD_IDLE;
        else                       rd_beat_d  = rd_beat_q + 8'd1;
      end
    endcase

    case (wr_state_q)
      WR_IDLE: if (s_aw_fire) begin
        if (aw_hit) wr_state_d = WR_FWD;
        else begin
          wr_state_d   = WR_ERR_W;
          wr_id_d      = s.aw_id;
          wlast_seen_d = 1'b0;
        end
      end
      WR_FWD: if (s_w_fire && s.w_last) wr_state_d = WR_IDLE;
      // The local B must trail every downstream B, so park here until they drain.
      WR_ERR_W: begin
        if (s_w_fire && s.w_last) wlast_seen_d = 1'b1;
        if ((wlast_seen_q || (s_w_fire && s.w_last)) && wr_cnt_d == 8'd0)
          wr_state_d = WR_ERR_B;
      end
      WR_ERR_B: if (s_b_fire) wr_state_d = WR_IDLE;
    endcase
  end

  always_comb begin
    m.ar_addr  = DST_BASE | (s.ar_addr & MASK);
    m.ar_id    = s.ar_id;
    m.ar_len   = s.ar_len;
    m.ar_size  = s.ar_size;
    m.ar_burst = s.ar_burst;
    m.ar_cache = s.ar_cache;
    m.ar_lock  = s.ar_lock;
    m.ar_prot  = s.ar_prot;
    m.ar_qos   = s.ar_qos;
    m.ar_valid = s.ar_valid & ar_hit & rd_gate;
    // Misses wait for an empty downstream so error beats never interleave with real data.
    s.ar_ready = ar_hit ? (m.ar_ready & rd_gate)
                        : (live_q && rd_state_q == RD_IDLE && rd_cnt_q == 8'd0);

    m.aw_addr  = DST_BASE | (s.aw_addr & MASK);
    m.aw_id    = s.aw_id;
    m.aw_len   = s.aw_len;
    m.aw_size  = s.aw_size;
    m.aw_burst = s.aw_burst;
    m.aw_cache = s.aw_cache;
    m.aw_lock  = s.aw_lock;
    m.aw_prot  = s.aw_prot;
    m.aw_qos   = s.aw_qos;
    m.aw_valid = s.aw_valid & aw_hit & wr_gate;
    s.aw_ready = aw_hit ? (m.aw_ready & wr_gate) : (live_q && wr_state_q == WR_IDLE);

    m.w_data  = s.w_data;
    m.w_strb  = s.w_strb;
    m.w_last  = s.w_last;
    m.w_valid = live_q & s.w_valid & (wr_state_q == WR_FWD);
    s.w_ready = 1'b0;
    if (live_q && wr_state_q == WR_FWD)   s.w_ready = m.w_ready;
    if (live_q && wr_state_q == WR_ERR_W) s.w_ready = !wlast_seen_q;

    if (rd_state_q == RD_ERR) begin
      s.r_valid = 1'b1;
      s.r_id    = rd_id_q;
      s.r_resp  = 2'b11;
      s.r_data  = ERR_DATA;
      s.r_last  = rd_beat_q == rd_len_q;
      m.r_ready = 1'b0;
    end else begin
      s.r_valid = live_q & m.r_valid;
      s.r_id    = m.r_id;
      s.r_resp  = m.r_resp;
      s.r_data  = m.r_data;
      s.r_last  = m.r_last;
      m.r_ready = live_q & s.r_ready;
    end

    if (wr_state_q == WR_ERR_B) begin
      s.b_valid = 1'b1;
      s.b_id    = wr_id_q;
      s.b_resp  = 2'b11;
      m.b_ready = 1'b0;
    end else begin
      s.b_valid = live_q & m.b_valid;
      s.b_id    = m.b_id;
      s.b_resp  = m.b_resp;
      m.b_ready = live_q & s.b_ready;
    end
  end

`ifdef MEM_WIN_PERF_EN
  logic [31:0] perf_rd_q, perf_rd_d, perf_wr_q, perf_wr_d, perf_err_q, perf_err_d;

  function automatic logic [31:0] sat_add(input logic [31:0] v, input logic [1:0] inc);
    logic [32:0] sum;
    sum = {1'b0, v} + {31'd0, inc};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  always_comb begin
    perf_rd_d  = sat_add(perf_rd_q, {1'b0, s_ar_fire});
    perf_wr_d  = sat_add(perf_wr_q, {1'b0, s_aw_fire});
    perf_err_d = sat_add(perf_err_q, {1'b0, s_ar_fire & ~ar_hit} + {1'b0, s_aw_fire & ~aw_hit});
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_rd_q  <= '0;
      perf_wr_q  <= '0;
      perf_err_q <= '0;
    end else begin
      perf_rd_q  <= perf_rd_d;
      perf_wr_q  <= perf_wr_d;
      perf_err_q <= perf_err_d;
    end
  end

  assign perf_rd_bursts = perf_rd_q;
  assign perf_wr_bursts = perf_wr_q;
  assign perf_decerr    = perf_err_q;
`else
  assign perf_rd_bursts = '0;
  assign perf_wr_bursts = '0;
  assign perf_decerr    = '0;
`endif
endmodule

// File: tb/tb_rocket_mem_window.sv
// Directed bench for rocket_mem_window (MAX_OUT=2): remap, DECERR reads/writes, throttling, reset.
module tb_rocket_mem_window;
  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] perf_rd_bursts, perf_wr_bursts, perf_decerr;
  int          errors = 0;
  int          checks = 0;
  logic        seen;

  rocket_mem_window_if #(.ADDR_W(32), .DATA_W(64), .ID_W(6)) s_if ();
  rocket_mem_window_if #(.ADDR_W(32), .DATA_W(64), .ID_W(6)) m_if ();

  rocket_mem_window #(.MAX_OUT(2)) dut (
    .clock(clock), .reset_n(reset_n), .s(s_if), .m(m_if),
    .perf_rd_bursts(perf_rd_bursts), .perf_wr_bursts(perf_wr_bursts), .perf_decerr(perf_decerr)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic s_ar(input logic v, input logic [31:0] a, input logic [5:0] id, input logic [7:0] len);
    s_if.ar_valid = v; s_if.ar_addr = a; s_if.ar_id = id; s_if.ar_len = len;
  endtask

  task automatic s_aw(input logic v, input logic [31:0] a, input logic [5:0] id, input logic [7:0] len);
    s_if.aw_valid = v; s_if.aw_addr = a; s_if.aw_id = id; s_if.aw_len = len;
  endtask

  task automatic m_r(input logic v, input logic [5:0] id, input logic [63:0] d, input logic last);
    m_if.r_valid = v; m_if.r_id = id; m_if.r_data = d; m_if.r_last = last; m_if.r_resp = 2'b00;
  endtask

  initial begin
    reset_n = 1'b0;
    s_ar(1'b1, 32'h0, 6'd0, 8'd0);
    s_aw(1'b0, 32'h0, 6'd0, 8'd0);
    s_if.ar_size = 3'd3; s_if.ar_burst = 2'b01; s_if.ar_cache = 4'd0; s_if.ar_lock = 1'b0;
    s_if.ar_prot = 3'd0; s_if.ar_qos = 4'd0;
    s_if.aw_size = 3'd3; s_if.aw_burst = 2'b01; s_if.aw_cache = 4'd0; s_if.aw_lock = 1'b0;
    s_if.aw_prot = 3'd0; s_if.aw_qos = 4'd0;
    s_if.w_valid = 1'b0; s_if.w_data = '0; s_if.w_strb = '1; s_if.w_last = 1'b0;
    s_if.r_ready = 1'b1; s_if.b_ready = 1'b1;
    m_if.ar_ready = 1'b1; m_if.aw_ready = 1'b1; m_if.w_ready = 1'b1;
    m_r(1'b1, 6'd0, 64'h0, 1'b0);
    m_if.b_valid = 1'b0; m_if.b_id = '0; m_if.b_resp = 2'b00;

    // Reset: everything quiet even with stimulus present.
    #1;
    chk("rst_s_ar_ready", s_if.ar_ready, 1'b0);
    chk("rst_s_aw_ready", s_if.aw_ready, 1'b0);
    chk("rst_s_w_ready", s_if.w_ready, 1'b0);
    chk("rst_s_r_valid", s_if.r_valid, 1'b0);
    chk("rst_s_b_valid", s_if.b_valid, 1'b0);
    chk("rst_m_ar_valid", m_if.ar_valid, 1'b0);
    chk("rst_perf_decerr", perf_decerr, 32'd0);
    chk("rst_perf_rd", perf_rd_bursts, 32'd0);
    s_ar(1'b0, 32'h0, 6'd0, 8'd0);
    m_r(1'b0, 6'd0, 64'h0, 1'b0);
    #1 reset_n = 1'b1;
    tick();

    // 1: in-window AR remapped same cycle, 4 beats pass through.
    s_ar(1'b1, 32'h8000_1040, 6'd1, 8'd3);
    #1;
    chk("t1_m_ar_valid", m_if.ar_valid, 1'b1);
    chk("t1_m_ar_addr", m_if.ar_addr, 32'h1000_1040);
    chk("t1_m_ar_len", m_if.ar_len, 8'd3);
    chk("t1_s_ar_ready", s_if.ar_ready, 1'b1);
    tick();
    s_ar(1'b0, 32'h0, 6'd0, 8'd0);
    for (int b = 0; b < 4; b++) begin
      m_r(1'b1, 6'd1, 64'hA0 + 64'(b), b == 3);
      #1;
      chk("t1_r_valid", s_if.r_valid, 1'b1);
      chk("t1_r_data", s_if.r_data, 64'hA0 + 64'(b));
      chk("t1_r_last", s_if.r_last, b == 3);
      tick();
    end
    m_r(1'b0, 6'd0, 64'h0, 1'b0);

    // 2: out-of-window AR held while two reads are outstanding, then local DECERR.
    s_ar(1'b1, 32'h8000_0010, 6'd2, 8'd0); tick();
    s_ar(1'b1, 32'h8000_0020, 6'd3, 8'd0); tick();
    s_ar(1'b1, 32'h9000_0000, 6'd5, 8'd1);
    #1;
    chk("t2_held_ready", s_if.ar_ready, 1'b0);
    chk("t2_no_m_ar", m_if.ar_valid, 1'b0);
    tick();
    m_r(1'b1, 6'd2, 64'h1, 1'b1);
    #1 chk("t2_held_cnt2", s_if.ar_ready, 1'b0);
    tick();
    m_r(1'b1, 6'd3, 64'h2, 1'b1);
    #1 chk("t2_held_cnt1", s_if.ar_ready, 1'b0);
    tick();
    m_r(1'b0, 6'd0, 64'h0, 1'b0);
    #1;
    chk("t2_accept", s_if.ar_ready, 1'b1);
    chk("t2_no_m_ar2", m_if.ar_valid, 1'b0);
    tick();
    s_ar(1'b0, 32'h0, 6'd0, 8'd0);
    #1;
    chk("t2_b1_valid", s_if.r_valid, 1'b1);
    chk("t2_b1_resp", s_if.r_resp, 2'b11);
    chk("t2_b1_data", s_if.r_data, 64'h0);
    chk("t2_b1_id", s_if.r_id, 6'd5);
    chk("t2_b1_last", s_if.r_last, 1'b0);
    tick();
    #1;
    chk("t2_b2_valid", s_if.r_valid, 1'b1);
    chk("t2_b2_last", s_if.r_last, 1'b1);
    chk("t2_b2_id", s_if.r_id, 6'd5);
    tick();
    #1 chk("t2_done", s_if.r_valid, 1'b0);

    // 3: MAX_OUT=2 throttles the third AR until one rlast returns.
    s_ar(1'b1, 32'h8000_0000, 6'd10, 8'd0);
    #1 chk("t3_ar1", s_if.ar_ready, 1'b1);
    tick();
    s_ar(1'b1, 32'h8000_0040, 6'd11, 8'd0);
    #1 chk("t3_ar2", s_if.ar_ready, 1'b1);
    tick();
    s_ar(1'b1, 32'h8000_0080, 6'd12, 8'd0);
    #1;
    chk("t3_ar3_held", s_if.ar_ready, 1'b0);
    chk("t3_ar3_m_valid", m_if.ar_valid, 1'b0);
    tick();
    m_r(1'b1, 6'd10, 64'h10, 1'b1);
    #1 chk("t3_still_held", s_if.ar_ready, 1'b0);
    tick();
    m_r(1'b0, 6'd0, 64'h0, 1'b0);
    #1;
    chk("t3_issue_valid", m_if.ar_valid, 1'b1);
    chk("t3_issue_ready", s_if.ar_ready, 1'b1);
    chk("t3_issue_id", m_if.ar_id, 6'd12);
    chk("t3_issue_addr", m_if.ar_addr, 32'h1000_0080);
    tick();
    s_ar(1'b0, 32'h0, 6'd0, 8'd0);
    m_r(1'b1, 6'd11, 64'h11, 1'b1); tick();
    m_r(1'b1, 6'd12, 64'h12, 1'b1); tick();
    m_r(1'b0, 6'd0, 64'h0, 1'b0);

    // 4: out-of-window write burst absorbed, one DECERR B after wlast.
    s_aw(1'b1, 32'h0000_0100, 6'd20, 8'd7);
    #1;
    chk("t4_aw_ready", s_if.aw_ready, 1'b1);
    chk("t4_no_m_aw", m_if.aw_valid, 1'b0);
    tick();
    s_aw(1'b0, 32'h0, 6'd0, 8'd0);
    seen = 1'b0;
    for (int b = 0; b < 8; b++) begin
      s_if.w_valid = 1'b1; s_if.w_data = 64'(b); s_if.w_last = (b == 7);
      #1;
      if (m_if.w_valid) seen = 1'b1;
      chk("t4_w_ready", s_if.w_ready, 1'b1);
      chk("t4_no_early_b", s_if.b_valid, 1'b0);
      tick();
    end
    s_if.w_valid = 1'b0; s_if.w_last = 1'b0;
    chk("t4_m_w_never", seen, 1'b0);
    #1;
    chk("t4_b_valid", s_if.b_valid, 1'b1);
    chk("t4_b_resp", s_if.b_resp, 2'b11);
    chk("t4_b_id", s_if.b_id, 6'd20);
    tick();
    #1 chk("t4_b_done", s_if.b_valid, 1'b0);

    // 5: local DECERR B must follow the delayed downstream B.
    s_aw(1'b1, 32'h8000_0200, 6'd7, 8'd0);
    #1;
    chk("t5_m_aw_valid", m_if.aw_valid, 1'b1);
    chk("t5_m_aw_addr", m_if.aw_addr, 32'h1000_0200);
    tick();
    s_aw(1'b0, 32'h0, 6'd0, 8'd0);
    s_if.w_valid = 1'b1; s_if.w_data = 64'h55; s_if.w_last = 1'b1;
    #1;
    chk("t5_m_w_valid", m_if.w_valid, 1'b1);
    chk("t5_s_w_ready", s_if.w_ready, 1'b1);
    tick();
    s_if.w_valid = 1'b0;
    s_aw(1'b1, 32'h0000_0000, 6'd9, 8'd0);
    #1 chk("t5_err_aw_ready", s_if.aw_ready, 1'b1);
    tick();
    s_aw(1'b0, 32'h0, 6'd0, 8'd0);
    s_if.w_valid = 1'b1; s_if.w_last = 1'b1;
    tick();
    s_if.w_valid = 1'b0; s_if.w_last = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1 if (s_if.b_valid) seen = 1'b1;
      tick();
    end
    chk("t5_no_early_b", seen, 1'b0);
    m_if.b_valid = 1'b1; m_if.b_id = 6'd7; m_if.b_resp = 2'b00;
    #1;
    chk("t5_ds_b_valid", s_if.b_valid, 1'b1);
    chk("t5_ds_b_id", s_if.b_id, 6'd7);
    chk("t5_ds_b_resp", s_if.b_resp, 2'b00);
    tick();
    m_if.b_valid = 1'b0;
    #1;
    chk("t5_err_b_valid", s_if.b_valid, 1'b1);
    chk("t5_err_b_id", s_if.b_id, 6'd9);
    chk("t5_err_b_resp", s_if.b_resp, 2'b11);
    chk("t5_m_b_ready", m_if.b_ready, 1'b0);
    tick();
    #1 chk("t5_b_done", s_if.b_valid, 1'b0);

    // 6: async reset in the middle of a DECERR read burst.
    s_ar(1'b1, 32'h9000_0000, 6'd4, 8'd3);
    #1 chk("t6_ar_ready", s_if.ar_ready, 1'b1);
    tick();
    s_ar(1'b0, 32'h0, 6'd0, 8'd0);
    tick();
    #1;
    chk("t6_beat2_valid", s_if.r_valid, 1'b1);
    chk("t6_beat2_last", s_if.r_last, 1'b0);
`ifdef MEM_WIN_PERF_EN
    chk("t6_perf_rd", perf_rd_bursts, 32'd8);
    chk("t6_perf_wr", perf_wr_bursts, 32'd3);
    chk("t6_perf_decerr", perf_decerr, 32'd4);
`endif
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_r_valid", s_if.r_valid, 1'b0);
    chk("t6_rst_perf_decerr", perf_decerr, 32'd0);
    chk("t6_rst_ar_ready", s_if.ar_ready, 1'b0);
    #2 reset_n = 1'b1;
    tick();
    s_ar(1'b1, 32'h8000_0400, 6'd6, 8'd0);
    #1;
    chk("t6_fresh_ready", s_if.ar_ready, 1'b1);
    chk("t6_fresh_m_valid", m_if.ar_valid, 1'b1);
    chk("t6_fresh_addr", m_if.ar_addr, 32'h1000_0400);
    tick();
    s_ar(1'b0, 32'h0, 6'd0, 8'd0);
    #1 chk("t6_r_quiet", s_if.r_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
